// File: rtl/usr_pkg.sv
// Shared definitions for the parametrised universal shift register:
// operation codes, FSM state encoding and operation-class helper.
package usr_pkg;

    localparam logic [2:0] OP_HOLD = 3'b000;
    localparam logic [2:0] OP_SHR  = 3'b001;
    localparam logic [2:0] OP_SHL  = 3'b010;
    localparam logic [2:0] OP_LOAD = 3'b011;
    localparam logic [2:0] OP_ROR  = 3'b100;
    localparam logic [2:0] OP_ROL  = 3'b101;
    localparam logic [2:0] OP_ASR  = 3'b110;
    localparam logic [2:0] OP_CLR  = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    // Shift-class ops are the only ones that move bits out of the register.
    function automatic logic is_shift_op(input logic [2:0] op);
        case (op)
            OP_SHR, OP_SHL, OP_ROR, OP_ROL, OP_ASR: is_shift_op = 1'b1;
            default:                                is_shift_op = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/usr_shift_core.sv
// Combinational next-state datapath of the shift register: computes the
// next register value for an op and exposes the bits at both ends.
module usr_shift_core
    import usr_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] i_q,
    input  logic [2:0]            i_op,
    input  logic [DATA_WIDTH-1:0] i_in,
    input  logic                  i_sr,
    input  logic                  i_sl,
    output logic [DATA_WIDTH-1:0] o_q_next,
    output logic                  o_out_lsb,
    output logic                  o_out_msb
);

    assign o_out_lsb = i_q[0];
    assign o_out_msb = i_q[DATA_WIDTH-1];

    always_comb begin
        o_q_next = i_q;
        case (i_op)
            OP_HOLD: o_q_next = i_q;
            OP_SHR:  o_q_next = {i_sr, i_q[DATA_WIDTH-1:1]};
            OP_SHL:  o_q_next = {i_q[DATA_WIDTH-2:0], i_sl};
            OP_LOAD: o_q_next = i_in;
            OP_ROR:  o_q_next = {i_q[0], i_q[DATA_WIDTH-1:1]};
            OP_ROL:  o_q_next = {i_q[DATA_WIDTH-2:0], i_q[DATA_WIDTH-1]};
            OP_ASR:  o_q_next = {i_q[DATA_WIDTH-1], i_q[DATA_WIDTH-1:1]};
            OP_CLR:  o_q_next = '0;
            default: o_q_next = i_q;
        endcase
    end

endmodule

// File: rtl/universal_shift_reg_param.sv
// Parametrised universal shift register with single-cycle ops and a
// multi-cycle burst-shift engine (IDLE -> RUN -> DONE handshake).
module universal_shift_reg_param
    import usr_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = $clog2(DATA_WIDTH) + 1
) (
    input  logic                  i_clk,
    input  logic                  clr,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] in,
    input  logic [2:0]            sel_mux,
    input  logic                  sr,
    input  logic                  sl,
    input  logic                  start,
    input  logic [CNT_WIDTH-1:0]  shamt,
    output logic                  busy,
    output logic                  done,
    output logic                  so_r,
    output logic                  so_l,
    output logic [DATA_WIDTH-1:0] q_out
);

    state_t                r_state;
    logic [2:0]            r_op;
    logic [CNT_WIDTH-1:0]  r_cnt;
    logic [DATA_WIDTH-1:0] r_q;
    logic                  r_so_r;
    logic                  r_so_l;

    logic [2:0]            w_op;
    logic [DATA_WIDTH-1:0] w_q_next;
    logic                  w_out_lsb;
    logic                  w_out_msb;

    // During a burst the latched op drives the datapath; sel_mux is ignored.
    assign w_op = (r_state == ST_RUN) ? r_op : sel_mux;

    usr_shift_core #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_core (
        .i_q       (r_q),
        .i_op      (w_op),
        .i_in      (in),
        .i_sr      (sr),
        .i_sl      (sl),
        .o_q_next  (w_q_next),
        .o_out_lsb (w_out_lsb),
        .o_out_msb (w_out_msb)
    );

    always_ff @(posedge i_clk or posedge clr) begin
        if (clr) begin
            r_state <= ST_IDLE;
            r_op    <= OP_HOLD;
            r_cnt   <= '0;
            r_q     <= '0;
            r_so_r  <= 1'b0;
            r_so_l  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        if (is_shift_op(sel_mux) && (shamt != '0)) begin
                            r_op    <= sel_mux;
                            r_cnt   <= shamt;
                            r_state <= ST_RUN;
                        end else begin
                            r_state <= ST_DONE;
                        end
                    end else if (en) begin
                        r_q <= w_q_next;
                        if (is_shift_op(sel_mux)) begin
                            r_so_r <= w_out_lsb;
                            r_so_l <= w_out_msb;
                        end
                    end
                end
                ST_RUN: begin
                    r_q    <= w_q_next;
                    r_so_r <= w_out_lsb;
                    r_so_l <= w_out_msb;
                    r_cnt  <= r_cnt - CNT_WIDTH'(1);
                    if (r_cnt == CNT_WIDTH'(1)) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy  = (r_state == ST_RUN);
    assign done  = (r_state == ST_DONE);
    assign so_r  = r_so_r;
    assign so_l  = r_so_l;
    assign q_out = r_q;

endmodule

// File: tb/tb_universal_shift_reg_param.sv
// Directed bench for universal_shift_reg_param (DATA_WIDTH=8): single-cycle
// ops, burst rotate/ASR, degenerate starts, serial streaming and async reset.
module tb_universal_shift_reg_param;

    localparam int DW = 8;
    localparam int CW = $clog2(DW) + 1;

    logic          clk;
    logic          clr;
    logic          en;
    logic [DW-1:0] in_d;
    logic [2:0]    sel_mux;
    logic          sr;
    logic          sl;
    logic          start;
    logic [CW-1:0] shamt;
    logic          busy;
    logic          done;
    logic          so_r;
    logic          so_l;
    logic [DW-1:0] q_out;

    int total;
    int bad;

    universal_shift_reg_param #(
        .DATA_WIDTH(DW)
    ) dut (
        .i_clk   (clk),
        .clr     (clr),
        .en      (en),
        .in      (in_d),
        .sel_mux (sel_mux),
        .sr      (sr),
        .sl      (sl),
        .start   (start),
        .shamt   (shamt),
        .busy    (busy),
        .done    (done),
        .so_r    (so_r),
        .so_l    (so_l),
        .q_out   (q_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_value(input logic [DW-1:0] v);
        en = 1'b1; sel_mux = 3'b011; in_d = v; start = 1'b0;
        tick();
        en = 1'b0; sel_mux = 3'b000;
    endtask

    task automatic test_reset();
        clr = 1'b1; en = 1'b0; in_d = '0; sel_mux = 3'b000;
        sr = 1'b0; sl = 1'b0; start = 1'b0; shamt = '0;
        #12;
        total++;
        if (q_out !== 8'h00 || busy !== 1'b0 || done !== 1'b0 || so_r !== 1'b0 || so_l !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: got q=%h busy=%b done=%b so_r=%b so_l=%b expected all zero",
                     q_out, busy, done, so_r, so_l);
        end
        #1 clr = 1'b0;
        tick();
        $display("txn reset: q=%h busy=%b done=%b", q_out, busy, done);
    endtask

    task automatic test_single_ops();
        load_value(8'hA5);
        total++;
        if (q_out !== 8'hA5) begin
            bad++; $display("FAIL load: got %h expected a5", q_out);
        end
        $display("txn load: q=%h", q_out);

        en = 1'b1; sel_mux = 3'b001; sr = 1'b1;
        tick();
        total++;
        if (q_out !== 8'hD2 || so_r !== 1'b1 || so_l !== 1'b1) begin
            bad++; $display("FAIL shr: got q=%h so_r=%b so_l=%b expected d2/1/1", q_out, so_r, so_l);
        end
        $display("txn shr: q=%h so_r=%b", q_out, so_r);

        sel_mux = 3'b111; sr = 1'b0;
        tick();
        en = 1'b0; sel_mux = 3'b000;
        total++;
        if (q_out !== 8'h00 || so_r !== 1'b1) begin
            bad++; $display("FAIL clear: got q=%h so_r=%b expected 00/1", q_out, so_r);
        end
        $display("txn clear: q=%h so_r=%b", q_out, so_r);

        en = 1'b1; sel_mux = 3'b000;
        tick();
        en = 1'b0;
        total++;
        if (q_out !== 8'h00) begin
            bad++; $display("FAIL hold: got %h expected 00", q_out);
        end
    endtask

    task automatic test_burst_rotate();
        int busy_cnt;
        int done_cnt;
        logic [DW-1:0] q_at_done;
        busy_cnt = 0; done_cnt = 0; q_at_done = '0;
        load_value(8'h81);
        start = 1'b1; sel_mux = 3'b101; shamt = CW'(3);
        tick();
        start = 1'b0; sel_mux = 3'b000; shamt = '0;
        total++;
        if (busy !== 1'b1 || q_out !== 8'h81) begin
            bad++; $display("FAIL rol_start_edge: got busy=%b q=%h expected 1/81", busy, q_out);
        end
        for (int i = 0; i < 6; i++) begin
            if (busy === 1'b1) busy_cnt++;
            if (done === 1'b1) begin
                done_cnt++;
                q_at_done = q_out;
            end
            tick();
        end
        total++;
        if (busy_cnt != 3) begin
            bad++; $display("FAIL rol_busy_cycles: got %0d expected 3", busy_cnt);
        end
        total++;
        if (done_cnt != 1) begin
            bad++; $display("FAIL rol_done_pulses: got %0d expected 1", done_cnt);
        end
        total++;
        if (q_at_done !== 8'h0C || so_l !== 1'b0) begin
            bad++; $display("FAIL rol_result: got q=%h so_l=%b expected 0c/0", q_at_done, so_l);
        end
        $display("txn burst_rol: q=%h busy_cycles=%0d done_pulses=%0d", q_at_done, busy_cnt, done_cnt);
    endtask

    task automatic test_burst_asr();
        int busy_cnt;
        busy_cnt = 0;
        load_value(8'h90);
        sr = 1'b0;
        start = 1'b1; sel_mux = 3'b110; shamt = CW'(2);
        tick();
        start = 1'b0; sel_mux = 3'b000;
        while (busy === 1'b1 && busy_cnt < 20) begin
            busy_cnt++;
            tick();
        end
        total++;
        if (busy_cnt != 2) begin
            bad++; $display("FAIL asr_busy_cycles: got %0d expected 2", busy_cnt);
        end
        total++;
        if (done !== 1'b1 || q_out !== 8'hE4 || so_r !== 1'b0) begin
            bad++; $display("FAIL asr_result: got done=%b q=%h so_r=%b expected 1/e4/0", done, q_out, so_r);
        end
        $display("txn burst_asr: q=%h busy_cycles=%0d", q_out, busy_cnt);
        tick();
    endtask

    task automatic test_degenerate();
        start = 1'b1; sel_mux = 3'b001; shamt = '0;
        tick();
        start = 1'b0; sel_mux = 3'b000;
        total++;
        if (busy !== 1'b0 || done !== 1'b1 || q_out !== 8'hE4) begin
            bad++; $display("FAIL degen_shamt0: got busy=%b done=%b q=%h expected 0/1/e4", busy, done, q_out);
        end
        tick();
        total++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL degen_done_width: got done=%b busy=%b expected 0/0", done, busy);
        end
        $display("txn degen_shamt0: q=%h", q_out);

        start = 1'b1; sel_mux = 3'b011; in_d = 8'h33; shamt = CW'(5);
        tick();
        start = 1'b0; sel_mux = 3'b000; shamt = '0;
        total++;
        if (busy !== 1'b0 || done !== 1'b1 || q_out !== 8'hE4) begin
            bad++; $display("FAIL degen_load: got busy=%b done=%b q=%h expected 0/1/e4", busy, done, q_out);
        end
        tick();
        $display("txn degen_load: q=%h", q_out);
    endtask

    task automatic test_serial_stream();
        logic [7:0] seq;
        int busy_cnt;
        seq = 8'b1011_0010;
        busy_cnt = 0;
        en = 1'b1; sel_mux = 3'b111;
        tick();
        en = 1'b0;
        start = 1'b1; sel_mux = 3'b010; shamt = CW'(8);
        tick();
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (busy === 1'b1) busy_cnt++;
            sl = seq[7-i];
            if (i == 3) begin
                start = 1'b1; en = 1'b1; sel_mux = 3'b011; in_d = 8'hFF; shamt = CW'(1);
            end else begin
                start = 1'b0; en = 1'b0; sel_mux = 3'b010;
            end
            tick();
        end
        start = 1'b0; en = 1'b0; sel_mux = 3'b000; sl = 1'b0;
        total++;
        if (busy_cnt != 8) begin
            bad++; $display("FAIL stream_busy_cycles: got %0d expected 8", busy_cnt);
        end
        total++;
        if (done !== 1'b1 || q_out !== 8'hB2) begin
            bad++; $display("FAIL stream_result: got done=%b q=%h expected 1/b2", done, q_out);
        end
        total++;
        if (so_l !== 1'b0 || so_r !== 1'b1) begin
            bad++; $display("FAIL stream_so: got so_l=%b so_r=%b expected 0/1", so_l, so_r);
        end
        $display("txn serial_stream: q=%h", q_out);
        tick();
    endtask

    task automatic test_reset_midburst();
        load_value(8'h5A);
        start = 1'b1; sel_mux = 3'b100; shamt = CW'(10);
        tick();
        start = 1'b0; sel_mux = 3'b000;
        tick();
        total++;
        if (busy !== 1'b1 || q_out !== 8'h2D) begin
            bad++; $display("FAIL midburst_pre: got busy=%b q=%h expected 1/2d", busy, q_out);
        end
        #2 clr = 1'b1;
        #1;
        total++;
        if (q_out !== 8'h00 || busy !== 1'b0 || done !== 1'b0 || so_r !== 1'b0 || so_l !== 1'b0) begin
            bad++; $display("FAIL midburst_reset: got q=%h busy=%b done=%b so_r=%b so_l=%b expected all zero",
                            q_out, busy, done, so_r, so_l);
        end
        #1 clr = 1'b0;
        tick();
        start = 1'b1; sel_mux = 3'b001; sr = 1'b1; shamt = CW'(1);
        tick();
        start = 1'b0; sel_mux = 3'b000;
        total++;
        if (busy !== 1'b1) begin
            bad++; $display("FAIL restart_busy: got %b expected 1", busy);
        end
        tick();
        sr = 1'b0;
        total++;
        if (done !== 1'b1 || q_out !== 8'h80) begin
            bad++; $display("FAIL restart_result: got done=%b q=%h expected 1/80", done, q_out);
        end
        $display("txn reset_midburst: q=%h", q_out);
        tick();
    endtask

    initial begin
        total = 0;
        bad = 0;
        test_reset();
        test_single_ops();
        test_burst_rotate();
        test_burst_asr();
        test_degenerate();
        test_serial_stream();
        test_reset_midburst();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
